// File: rtl/mul_arbiter.sv
// mul_arbiter: shares one external pipelined 32x32 unsigned multiplier
// between N_REQ requesters. Round-robin grant, one issue per cycle, a
// requester-ID tracker that follows each op through the multiplier latency,
// and a credit-protected first-word-fall-through result FIFO so a product
// leaving the stall-free multiplier always has a slot to land in.
//
// Timing model: operands presented in cycle T are sampled from mul_r at the
// end of cycle T+MUL_LAT-1, so the first response is visible in T+MUL_LAT.
// The tracker stage that matches the issue cycle is the grant itself; the
// remaining MUL_LAT-1 stages are registers. MUL_LAT must be at least 2.
module mul_arbiter #(
    parameter int N_REQ      = 4,
    parameter int ID_W       = 2,
    parameter int MUL_LAT    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*32-1:0]   req_a,
    input  logic [N_REQ*32-1:0]   req_b,
    output logic [N_REQ-1:0]      req_ready,
    output logic [31:0]           mul_a,
    output logic [31:0]           mul_b,
    input  logic [63:0]           mul_r,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [63:0]           rsp_data,
    output logic                  busy
);

    // Registered tracker stages (the issue cycle itself is stage 0).
    localparam int TRK_N = MUL_LAT - 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    // Wide enough for fifo occupancy plus every op that can be in flight.
    localparam int CNT_W = $clog2(FIFO_DEPTH + MUL_LAT + 1);

    // ------------------------------------------------------------------
    // Arbitration state and signals
    // ------------------------------------------------------------------
    logic [ID_W-1:0]  r_ptr;
    logic             w_gnt_vld;
    logic [ID_W-1:0]  w_gnt_id;
    logic [ID_W:0]    w_scan_sum;
    logic [ID_W-1:0]  w_scan;
    logic             w_credit_ok;
    logic             w_issue;

    // ------------------------------------------------------------------
    // Tracker state
    // ------------------------------------------------------------------
    logic [TRK_N-1:0] r_trk_vld;
    logic [ID_W-1:0]  r_trk_id [TRK_N];
    logic [CNT_W-1:0] w_inflight;
    logic             w_push;
    logic [ID_W-1:0]  w_push_id;

    // ------------------------------------------------------------------
    // Result FIFO state
    // ------------------------------------------------------------------
    logic [63:0]      r_mem_data [FIFO_DEPTH];
    logic [ID_W-1:0]  r_mem_id   [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;

    // Pointer advance with wrap at FIFO_DEPTH (also correct for depth 1).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Round-robin scan: first valid requester at or above r_ptr, wrapping.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no
        // path through the loop can leave it unassigned and infer a latch.
        w_gnt_vld  = 1'b0;
        w_gnt_id   = '0;
        w_scan_sum = '0;
        w_scan     = '0;
        for (int off = 0; off < N_REQ; off++) begin
            w_scan_sum = {1'b0, r_ptr} + (ID_W+1)'(off);
            if (w_scan_sum >= (ID_W+1)'(N_REQ)) begin
                w_scan_sum = w_scan_sum - (ID_W+1)'(N_REQ);
            end
            w_scan = w_scan_sum[ID_W-1:0];
            if (!w_gnt_vld && req_valid[w_scan]) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = w_scan;
            end
        end
    end

    // Count valid registered tracker stages (ops whose product is pending).
    always_comb begin
        w_inflight = '0;
        for (int k = 0; k < TRK_N; k++) begin
            w_inflight = w_inflight + CNT_W'(r_trk_vld[k]);
        end
    end

    // A same-cycle pop is deliberately ignored: credit only counts space
    // that is already free, which keeps this path off rsp_ready.
    assign w_credit_ok = (r_count + w_inflight) < CNT_W'(FIFO_DEPTH);
    assign w_issue     = w_gnt_vld && w_credit_ok;
    assign req_ready   = w_issue ? (N_REQ'(1) << w_gnt_id) : '0;

    // Steer the granted operands to the multiplier; zeros when idle.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_issue && (w_gnt_id == ID_W'(i))) begin
                mul_a = req_a[i*32 +: 32];
                mul_b = req_b[i*32 +: 32];
            end
        end
    end

    // Advance the round-robin pointer past the requester just served.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_issue) begin
            r_ptr <= (w_gnt_id == ID_W'(N_REQ - 1)) ? '0 : w_gnt_id + ID_W'(1);
        end
    end

    // Shift {valid, id} along with the multiplier pipeline every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trk_vld <= '0;
            for (int k = 0; k < TRK_N; k++) begin
                r_trk_id[k] <= '0;
            end
        end else begin
            r_trk_vld[0] <= w_issue;
            r_trk_id[0]  <= w_gnt_id;
            for (int k = 1; k < TRK_N; k++) begin
                r_trk_vld[k] <= r_trk_vld[k-1];
                r_trk_id[k]  <= r_trk_id[k-1];
            end
        end
    end

    // The last tracker stage lines up with mul_r being stable.
    assign w_push    = r_trk_vld[TRK_N-1];
    assign w_push_id = r_trk_id[TRK_N-1];

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_pop   = !w_empty && rsp_ready;

    // Capture the product and its requester ID into the FIFO storage.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; occupancy is tracked by r_count and the
        // outputs are forced to zero while empty, so stale words never leak.
        if (w_push) begin
            r_mem_data[r_wptr] <= mul_r;
            r_mem_id[r_wptr]   <= w_push_id;
        end
    end

    // FIFO pointers and occupancy; push and pop together leave count as is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // First-word-fall-through view of the head entry.
    assign rsp_valid = !w_empty;
    assign rsp_id    = w_empty ? '0 : r_mem_id[r_rptr];
    assign rsp_data  = w_empty ? '0 : r_mem_data[r_rptr];
    assign busy      = (w_inflight != '0) || !w_empty;

    // The credit rule must make a push into a full FIFO without a pop impossible.
    a_no_overflow : assert property (
        @(posedge clk) disable iff (!rst_n) !(w_push && w_full && !w_pop)
    );

endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: scenario tasks drive the arbiter; a negedge monitor keeps a
// scoreboard of expected {id, product} in grant order and compares each
// response as it is popped. A behavioural pipelined multiplier closes the loop.
module tb_mul_arbiter;

    localparam int N_REQ      = 4;
    localparam int ID_W       = 2;
    localparam int MUL_LAT    = 2;
    localparam int FIFO_DEPTH = 4;

    logic                clk;
    logic                rst_n;
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*32-1:0] req_a;
    logic [N_REQ*32-1:0] req_b;
    logic [N_REQ-1:0]    req_ready;
    logic [31:0]         mul_a;
    logic [31:0]         mul_b;
    logic [63:0]         mul_r;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [ID_W-1:0]     rsp_id;
    logic [63:0]         rsp_data;
    logic                busy;

    logic [31:0] op_a [N_REQ];
    logic [31:0] op_b [N_REQ];

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [63:0]     data;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic            mon_hold;
    logic [ID_W-1:0] mon_id;
    logic [63:0]     mon_data;

    mul_arbiter #(
        .N_REQ(N_REQ), .ID_W(ID_W), .MUL_LAT(MUL_LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .mul_a(mul_a), .mul_b(mul_b), .mul_r(mul_r),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .busy(busy)
    );

    for (genvar g = 0; g < N_REQ; g++) begin : g_pack
        assign req_a[g*32 +: 32] = op_a[g];
        assign req_b[g*32 +: 32] = op_b[g];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External multiplier: product sampled by the arbiter MUL_LAT edges later.
    initial mul_r = '0;
    always @(posedge clk) mul_r <= 64'(mul_a) * 64'(mul_b);

    // Scoreboard monitor: pop/compare responses, then record new grants.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mon_hold) begin
                n_checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== mon_id || rsp_data !== mon_data) begin
                    n_fail++;
                    $display("FAIL hold_stable: got v=%b id=%0d data=%h required v=1 id=%0d data=%h",
                             rsp_valid, rsp_id, rsp_data, mon_id, mon_data);
                end
            end
            if (rsp_valid && rsp_ready) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_rsp: got id=%0d data=%h required no response",
                             rsp_id, rsp_data);
                end else begin
                    mon_e = sb_q.pop_front();
                    if (rsp_id !== mon_e.id || rsp_data !== mon_e.data) begin
                        n_fail++;
                        $display("FAIL rsp_order: got id=%0d data=%h required id=%0d data=%h",
                                 rsp_id, rsp_data, mon_e.id, mon_e.data);
                    end
                end
            end
            if (req_ready != '0) begin
                n_checks++;
                if (!$onehot(req_ready) || ((req_ready & ~req_valid) != '0)) begin
                    n_fail++;
                    $display("FAIL grant_onehot: got ready=%b valid=%b required one-hot subset",
                             req_ready, req_valid);
                end
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    mon_e.id   = ID_W'(i);
                    mon_e.data = 64'(op_a[i]) * 64'(op_b[i]);
                    sb_q.push_back(mon_e);
                end
            end
            mon_hold = rsp_valid && !rsp_ready;
            mon_id   = rsp_id;
            mon_data = rsp_data;
        end else begin
            mon_hold = 1'b0;
        end
    end

    // Move to just after the next rising edge, where inputs are driven.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Let everything in flight or buffered drain, then confirm nothing is left.
    task automatic drain();
        bit done;
        cyc();
        req_valid = '0;
        rsp_ready = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL drain_timeout: got busy=%b required 0 within 50 cycles", busy);
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_empty: got %0d outstanding required 0", sb_q.size());
        end
        cyc();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got rsp_valid=%b busy=%b required 0 0", rsp_valid, busy);
        end
        n_checks++;
        if (rsp_data !== 64'd0 || rsp_id !== '0) begin
            n_fail++;
            $display("FAIL reset_rsp: got id=%0d data=%h required 0 0", rsp_id, rsp_data);
        end
        #2 rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [N_REQ-1:0] exp_g;
        int               k;
        cyc();
        for (int i = 0; i < N_REQ; i++) begin
            op_a[i] = 32'(i + 1);
            op_b[i] = 32'd10;
        end
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c == 8) req_valid = '0;
            @(negedge clk);
            if (c < 8) begin
                exp_g = N_REQ'(1) << (c % 4);
                n_checks++;
                if (req_ready !== exp_g) begin
                    n_fail++;
                    $display("FAIL rr_grant c=%0d: got %b required %b", c, req_ready, exp_g);
                end
            end
            if (c >= MUL_LAT) begin
                k = (c - MUL_LAT) % 4;
                n_checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== ID_W'(k) || rsp_data !== 64'(10 * (k + 1))) begin
                    n_fail++;
                    $display("FAIL rr_rsp c=%0d: got v=%b id=%0d data=%0d required v=1 id=%0d data=%0d",
                             c, rsp_valid, rsp_id, rsp_data, k, 10 * (k + 1));
                end
            end else begin
                n_checks++;
                if (rsp_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rr_early c=%0d: got rsp_valid=%b required 0", c, rsp_valid);
                end
            end
            cyc();
        end
        drain();
    endtask

    task automatic test_single_op();
        op_a[2]   = 32'hFFFF_FFFF;
        op_b[2]   = 32'hFFFF_FFFF;
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 4'b0100 || mul_a !== 32'hFFFF_FFFF || mul_b !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL single_grant: got ready=%b a=%h b=%h required 0100 ffffffff ffffffff",
                     req_ready, mul_a, mul_b);
        end
        cyc();
        req_valid = '0;
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_t1: got rsp_valid=%b busy=%b required 0 1", rsp_valid, busy);
        end
        cyc();
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 64'hFFFF_FFFE_0000_0001) begin
            n_fail++;
            $display("FAIL single_rsp: got v=%b id=%0d data=%h required 1 2 fffffffe00000001",
                     rsp_valid, rsp_id, rsp_data);
        end
        cyc();
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: got busy=%b rsp_valid=%b required 0 0", busy, rsp_valid);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int n_gnt;
        int n_res;
        bit g;
        op_a[0]   = 32'd3;
        op_b[0]   = 32'd5;
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        n_gnt     = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_checks++;
            if (req_ready[0] !== (c < 4)) begin
                n_fail++;
                $display("FAIL bp_grant c=%0d: got %b required %b", c, req_ready[0], (c < 4));
            end
            if (req_ready[0]) n_gnt++;
            cyc();
        end
        n_checks++;
        if (n_gnt != 4) begin
            n_fail++;
            $display("FAIL bp_count: got %0d grants required 4", n_gnt);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_data !== 64'd15) begin
            n_fail++;
            $display("FAIL bp_full: got ready=%b v=%b data=%0d required 0000 1 15",
                     req_ready, rsp_valid, rsp_data);
        end
        cyc();
        n_res = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            g = req_ready[0];
            if (g) n_res++;
            cyc();
            if (g) op_a[0] = op_a[0] + 32'd1;
        end
        n_checks++;
        if (n_res != 8) begin
            n_fail++;
            $display("FAIL bp_resume: got %0d grants required 8", n_res);
        end
        drain();
    endtask

    task automatic test_full_push_pop();
        int n_rsp;
        op_b[0]   = 32'd7;
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            op_a[0] = 32'(100 + c);
            @(negedge clk);
            n_checks++;
            if (req_ready !== 4'b0001) begin
                n_fail++;
                $display("FAIL fp_fill c=%0d: got %b required 0001", c, req_ready);
            end
            cyc();
        end
        op_a[1]   = 32'd9;
        op_b[1]   = 32'd11;
        req_valid = 4'b0010;
        rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 64'd700) begin
            n_fail++;
            $display("FAIL fp_pushpop: got ready=%b v=%b id=%0d data=%0d required 0000 1 0 700",
                     req_ready, rsp_valid, rsp_id, rsp_data);
        end
        cyc();
        rsp_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 4'b0010 || rsp_data !== 64'd707) begin
            n_fail++;
            $display("FAIL fp_count3: got ready=%b data=%0d required 0010 707", req_ready, rsp_data);
        end
        cyc();
        req_valid = '0;
        rsp_ready = 1'b1;
        n_rsp = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid) n_rsp++;
            cyc();
        end
        n_checks++;
        if (n_rsp != 4) begin
            n_fail++;
            $display("FAIL fp_drain: got %0d responses required 4", n_rsp);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        bit found;
        op_a[2]   = 32'd11;
        op_b[2]   = 32'd13;
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (req_ready !== 4'b0100) begin
                n_fail++;
                $display("FAIL rm_fill c=%0d: got %b required 0100", c, req_ready);
            end
            if (c < 3) cyc();
        end
        #2;
        rst_n     = 1'b0;
        req_valid = '0;
        sb_q.delete();
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_data !== 64'd0) begin
            n_fail++;
            $display("FAIL rm_async: got v=%b busy=%b data=%h required 0 0 0", rsp_valid, busy, rsp_data);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        cyc();
        op_a[1]   = 32'd7;
        op_b[1]   = 32'd6;
        op_a[3]   = 32'd2;
        op_b[3]   = 32'd3;
        req_valid = 4'b1010;
        rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL rm_ptr0: got %b required 0010", req_ready);
        end
        cyc();
        req_valid = 4'b1000;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL rm_next: got %b required 1000", req_ready);
        end
        cyc();
        req_valid = '0;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                found = 1'b1;
                n_checks++;
                if (rsp_id !== 2'd1 || rsp_data !== 64'd42) begin
                    n_fail++;
                    $display("FAIL rm_first: got id=%0d data=%0d required 1 42", rsp_id, rsp_data);
                end
            end
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL rm_timeout: got no response required one within 10 cycles");
        end
        drain();
    endtask

    task automatic test_idle();
        for (int i = 0; i < N_REQ; i++) begin
            op_a[i] = $urandom | 32'h1;
            op_b[i] = $urandom | 32'h1;
        end
        req_valid = '0;
        rsp_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if (mul_a !== 32'd0 || mul_b !== 32'd0 || req_ready !== '0 ||
                rsp_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL idle c=%0d: got a=%h b=%h ready=%b v=%b busy=%b required all 0",
                         c, mul_a, mul_b, req_ready, rsp_valid, busy);
            end
            cyc();
        end
    endtask

    initial begin
        mon_hold = 1'b0;
        mon_id   = '0;
        mon_data = '0;
        test_reset();
        test_round_robin();
        test_single_op();
        test_backpressure();
        test_full_push_pop();
        test_reset_mid();
        test_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion required finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mul_arbiter.md
Name: mul_arbiter

Overview:
- Shares one external pipelined 32x32 unsigned multiplier between N_REQ requesters.
- Round-robin arbitration; at most one operation issued per cycle.
- Tracks each in-flight op's requester ID through the multiplier's fixed latency.
- Buffers products in a credit-protected result FIFO, so the multiplier, which has no stall input, never loses a result under response backpressure.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- ID_W, 2, requester ID width, equal to clog2(N_REQ).
- MUL_LAT, 2, clock edges from operands presented on mul_a/mul_b to product stable on mul_r.
- FIFO_DEPTH, 4, result FIFO entries; power of 2, at least 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester operation request.
- req_a  in  N_REQ*32  operand A; requester i uses bits [32i+31:32i].
- req_b  in  N_REQ*32  operand B; same packing as req_a.
- req_ready  out  N_REQ  one-hot grant; the operation transfers when req_valid[i] and req_ready[i] are both high.
- mul_a  out  32  operand A to the multiplier.
- mul_b  out  32  operand B to the multiplier.
- mul_r  in  64  product from the multiplier.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  ID_W  requester index that the result belongs to.
- rsp_data  out  64  product a*b.
- busy  out  1  high while any op is in flight or the FIFO is non-empty.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - RR pointer = 0, tracker cleared, FIFO empty.
  - rsp_valid = 0, rsp_data = 0, rsp_id = 0, busy = 0.
  - Ops in flight or buffered at reset are discarded. No response is ever produced for them.
- Credit:
  - credit_ok = (fifo_count + inflight_count) < FIFO_DEPTH.
  - A pop in the same cycle is not counted as freeing space (conservative).
- Arbitration (combinational):
  - When credit_ok, grant the first i with req_valid[i] high, scanning from ptr upward and wrapping N_REQ-1 -> 0.
  - req_ready is one-hot or zero. It is zero when credit is unavailable or no request is valid.
  - req_ready[i] never depends on req_a or req_b.
- Pointer:
  - On an issue to requester g, ptr <= (g+1) mod N_REQ.
  - With no issue, ptr holds.
- Datapath:
  - On issue, mul_a/mul_b = the granted requester's operands.
  - Otherwise mul_a/mul_b = 0, so the multiplier does not toggle.
- Tracker:
  - MUL_LAT-stage shift register of {valid, id}, shifting every cycle.
  - Stage 0 is loaded with {issue, g}.
  - When the final stage is valid, the FIFO pushes {id, mul_r} at that edge.
  - inflight_count = number of valid tracker stages.
- Latency:
  - Op issued in cycle T has its product sampled at the end of cycle T+MUL_LAT-1.
  - rsp_valid is high from cycle T+MUL_LAT, given an empty FIFO.
  - Issue-to-response is exactly MUL_LAT cycles minimum.
- FIFO:
  - First-word-fall-through.
  - rsp_valid = !empty; rsp_id and rsp_data show the head entry.
  - Pop when rsp_valid && rsp_ready.
  - Simultaneous push and pop is legal at any occupancy, including full; count is unchanged.
  - Overflow is impossible by the credit rule. Add an assertion that a push never occurs when the FIFO is full without a pop.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Ordering: responses leave in issue order, across and within requesters.
- Throughput: with rsp_ready held high and FIFO_DEPTH >= MUL_LAT+2, one issue per cycle is sustained indefinitely.
- Stability:
  - rsp_id and rsp_data hold while rsp_valid && !rsp_ready.
  - Requesters keep req_a/req_b stable while req_valid is high and not granted. The arbiter does not check this.
- Arithmetic: unsigned 32x32 -> 64. rsp_data is mul_r verbatim; no truncation or sign handling.

Test Plan:
- Single op: requester 2 sends a=0xFFFFFFFF, b=0xFFFFFFFF, rsp_ready=1 -> req_ready=0b0100 in the same cycle; rsp_valid exactly MUL_LAT cycles later with rsp_id=2, rsp_data=0xFFFFFFFE00000001; busy returns to 0 the cycle after the pop.
- Round-robin: all 4 requesters valid continuously with a=i+1, b=10, rsp_ready=1 -> grants cycle 0,1,2,3,0,...; rsp_id sequence 0,1,2,3,0; rsp_data 10,20,30,40,10; one response per cycle in steady state.
- Backpressure: rsp_ready=0, requester 0 valid for 8 cycles with a=3, b=5 -> exactly 4 grants, then req_ready=0; 4 entries held, each 15. Then rsp_ready=1 -> 4 pops, after which issues resume with no loss and no duplication.
- Full with simultaneous push/pop: FIFO at 3 entries, 1 op in flight, rsp_ready=1 in the push cycle -> count stays 3; the no-overflow assertion never fires; data order is preserved.
- Reset mid-operation: drop rst_n asynchronously with 2 ops in flight and 2 buffered -> rsp_valid=0 and busy=0 immediately, ptr=0. After release, none of the 4 old results ever appear; a new op from requester 1 with a=7, b=6 returns 42 with rsp_id=1.
- Idle operands: no req_valid for 10 cycles -> mul_a=mul_b=0, req_ready=0, rsp_valid=0, busy=0.
